// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, fetches from a multi-cycle instruction memory and buffers one instruction for decode.
// Optional stall counter output enabled by defining FETCH_STALL_CNT_EN.
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic [15:0] if_pc_plus2,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
`ifdef FETCH_STALL_CNT_EN
  output logic [15:0] stall_cnt,
`endif
  output logic        halted
);

  localparam int unsigned XLEN = 16;

  typedef enum logic [1:0] {
    S_REQ    = 2'd0,
    S_WAIT   = 2'd1,
    S_DRAIN  = 2'd2,
    S_HALTED = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   bpc_q, bpc_d;
  logic [XLEN-1:0]   bpc2_q, bpc2_d;

  logic              consume;
  logic              req;
  logic              accept;
  logic [XLEN-1:0]   redirect_tgt;
  logic [XLEN-1:0]   pc_inc;

  // A request goes out only when the buffer will have room for its response.
  always_comb begin
    consume      = valid_q & id_ready;
    req          = ~rst & (state_q == S_REQ) & (~valid_q | id_ready);
    accept       = req & imem_ready;
    redirect_tgt = redirect_pc & ~XLEN'(1);
    pc_inc       = pc_q + XLEN'(2);
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    bpc_d   = bpc_q;
    bpc2_d  = bpc2_q;

    if (consume) begin
      valid_d = 1'b0;
    end

    if (redirect_valid) begin
      // Buffered instruction is on the wrong path; an in-flight response must be drained.
      pc_d    = redirect_tgt;
      valid_d = 1'b0;
      unique case (state_q)
        S_REQ:    state_d = accept ? S_DRAIN : S_REQ;
        S_WAIT:   state_d = imem_rvalid ? S_REQ : S_DRAIN;
        S_DRAIN:  state_d = imem_rvalid ? S_REQ : S_DRAIN;
        S_HALTED: state_d = S_REQ;
        default:  state_d = S_REQ;
      endcase
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (accept) begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            instr_d = imem_rdata;
            bpc_d   = pc_q;
            bpc2_d  = pc_inc;
            valid_d = 1'b1;
            pc_d    = pc_inc;
            state_d = (imem_rdata[15:12] == HLT_OPCODE) ? S_HALTED : S_REQ;
          end
        end
        S_DRAIN: begin
          if (imem_rvalid) begin
            state_d = S_REQ;
          end
        end
        S_HALTED: state_d = S_HALTED;
        default:  state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= '0;
      bpc_q   <= '0;
      bpc2_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      bpc_q   <= bpc_d;
      bpc2_q  <= bpc2_d;
    end
  end

  assign imem_req    = req;
  assign imem_addr   = rst ? RESET_PC : pc_q;
  assign if_valid    = valid_q;
  assign if_instr    = instr_q;
  assign if_pc       = bpc_q;
  assign if_pc_plus2 = bpc2_q;
  assign halted      = (state_q == S_HALTED);

`ifdef FETCH_STALL_CNT_EN
  logic [XLEN-1:0] stall_q;
  logic            stall_ev;

  // Memory backpressure, memory latency, or decode backpressure each cost a stall cycle.
  always_comb begin
    stall_ev = (req & ~imem_ready)
             | (((state_q == S_WAIT) | (state_q == S_DRAIN)) & ~imem_rvalid)
             | (valid_q & ~id_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (stall_ev && (stall_q != {XLEN{1'b1}})) begin
      stall_q <= stall_q + XLEN'(1);
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized traffic
// against a transaction-level model (outstanding/discard flags, expected PC, buffer contents).
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic [15:0] if_pc_plus2;
  logic        id_ready;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halted;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .if_pc_plus2   (if_pc_plus2),
    .id_ready      (id_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
`ifdef FETCH_STALL_CNT_EN
    .stall_cnt     (stall_cnt),
`endif
    .halted        (halted)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: fetch PC, one outstanding transaction (possibly wrong-path), halt flag, buffer.
  logic [15:0] m_pc;
  bit          m_out, m_disc, m_halt, m_bv;
  logic [15:0] m_bi, m_bp;
  bit          exp_req;

  // Memory responder state and knobs.
  bit          r_pend;
  int          r_cnt;
  logic [15:0] r_addr;
  int          cfg_ready_pct, cfg_lat_min, cfg_lat_max;
  bit          cfg_rand, cfg_spur;
  logic [15:0] cfg_word, cfg_hlt_addr;

  task automatic setup_cycle();
    imem_ready  = ($urandom_range(99) < cfg_ready_pct);
    imem_rvalid = (r_pend && r_cnt == 0) || (!r_pend && cfg_spur && $urandom_range(9) == 0);
    if (r_addr == cfg_hlt_addr) imem_rdata = 16'hF000;
    else if (cfg_rand)          imem_rdata = 16'($urandom);
    else                        imem_rdata = cfg_word;
    exp_req = !rst && !m_out && !m_halt && (!m_bv || id_ready);
    #1;
  endtask

  task automatic advance();
    bit acc, resp, cons;
    acc  = exp_req && imem_ready;
    resp = m_out && imem_rvalid;
    cons = m_bv && id_ready;
    if (rst) begin
      m_pc = 16'h0000; m_out = 0; m_disc = 0; m_halt = 0; m_bv = 0; m_bi = 0; m_bp = 0;
    end else begin
      if (cons) m_bv = 0;
      if (redirect_valid) begin
        m_pc   = redirect_pc & 16'hFFFE;
        m_bv   = 0;
        m_halt = 0;
        if (acc)       begin m_out = 1; m_disc = 1; end
        else if (resp) m_out = 0;
        else if (m_out) m_disc = 1;
      end else begin
        if (acc) begin m_out = 1; m_disc = 0; end
        if (resp) begin
          m_out = 0;
          if (!m_disc) begin
            m_bv = 1; m_bi = imem_rdata; m_bp = m_pc; m_pc = m_pc + 16'd2;
            if (imem_rdata[15:12] == 4'hF) m_halt = 1;
          end
        end
      end
    end
    if (rst) r_pend = 0;
    else begin
      if (r_pend && r_cnt == 0 && imem_rvalid) r_pend = 0;
      else if (r_pend) r_cnt--;
      if (imem_req && imem_ready) begin
        r_pend = 1;
        r_cnt  = int'($urandom_range(cfg_lat_max, cfg_lat_min));
        r_addr = imem_addr;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cfg_default();
    cfg_ready_pct = 100; cfg_lat_min = 0; cfg_lat_max = 0;
    cfg_rand = 0; cfg_spur = 0; cfg_word = 16'h1234; cfg_hlt_addr = 16'h0001;
    redirect_valid = 0; redirect_pc = 16'h0000; id_ready = 1;
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) begin setup_cycle(); advance(); end
    rst = 0;
  endtask

  task automatic test_reset();
    cfg_default();
    rst = 1;
    setup_cycle();
    n_vec++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req got %b exp 0", imem_req); end
    n_vec++; if (imem_addr !== 16'h0000) begin n_bad++; $display("FAIL reset_addr got %h exp 0000", imem_addr); end
    advance(); setup_cycle(); advance();
    rst = 0;
    n_vec++; if ({if_valid, halted} !== 2'b00) begin n_bad++; $display("FAIL reset_flags got %b exp 00", {if_valid, halted}); end
    n_vec++; if ({if_instr, if_pc, if_pc_plus2} !== 48'h0) begin n_bad++; $display("FAIL reset_buf got %h exp 0", {if_instr, if_pc, if_pc_plus2}); end
  endtask

  task automatic test_stream();
    for (int k = 0; k < 3; k++) begin
      setup_cycle();
      n_vec++; if (imem_req !== 1'b1 || imem_addr !== 16'(2 * k)) begin n_bad++; $display("FAIL stream_req k=%0d got %b/%h exp 1/%h", k, imem_req, imem_addr, 16'(2 * k)); end
      n_vec++; if (if_valid !== (k > 0)) begin n_bad++; $display("FAIL stream_valid k=%0d got %b exp %b", k, if_valid, k > 0); end
      if (k > 0) begin
        n_vec++;
        if (if_pc !== 16'(2 * k - 2) || if_pc_plus2 !== 16'(2 * k) || if_instr !== 16'h1234) begin
          n_bad++; $display("FAIL stream_buf k=%0d got %h/%h/%h exp %h/%h/1234", k, if_pc, if_pc_plus2, if_instr, 16'(2 * k - 2), 16'(2 * k));
        end
      end
      advance();
      setup_cycle();
      n_vec++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin n_bad++; $display("FAIL stream_gap k=%0d got req %b valid %b exp 0 0", k, imem_req, if_valid); end
      advance();
    end
  endtask

  task automatic test_backpressure();
    cfg_default(); do_reset();
    setup_cycle(); advance();
    setup_cycle(); advance();
    id_ready = 0;
    for (int i = 0; i < 5; i++) begin
      setup_cycle();
      n_vec++;
      if (if_valid !== 1'b1 || if_instr !== 16'h1234 || if_pc !== 16'h0000 || imem_req !== 1'b0) begin
        n_bad++; $display("FAIL bp_hold i=%0d got v%b %h %h req %b exp v1 1234 0000 req 0", i, if_valid, if_instr, if_pc, imem_req);
      end
      advance();
    end
    id_ready = 1;
    setup_cycle();
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 16'h0002) begin n_bad++; $display("FAIL bp_release got %b/%h exp 1/0002", imem_req, imem_addr); end
    advance();
  endtask

  task automatic test_redirect_wait();
    cfg_default(); do_reset();
    cfg_lat_min = 3; cfg_lat_max = 3;
    setup_cycle(); advance();
    redirect_valid = 1; redirect_pc = 16'h0041;
    setup_cycle();
    n_vec++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rw_wait_req got %b exp 0", imem_req); end
    advance();
    redirect_valid = 0;
    for (int i = 0; i < 3; i++) begin
      setup_cycle();
      n_vec++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin n_bad++; $display("FAIL rw_drain i=%0d got req %b valid %b exp 0 0", i, imem_req, if_valid); end
      advance();
    end
    setup_cycle();
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040 || if_valid !== 1'b0) begin n_bad++; $display("FAIL rw_target got %b/%h v%b exp 1/0040 v0", imem_req, imem_addr, if_valid); end
    advance();
  endtask

  task automatic test_redirect_rvalid();
    cfg_default(); do_reset();
    setup_cycle(); advance();
    redirect_valid = 1; redirect_pc = 16'h1237;
    setup_cycle();
    n_vec++; if (imem_rvalid !== 1'b1) begin n_bad++; $display("FAIL rr_setup got rvalid %b exp 1", imem_rvalid); end
    advance();
    redirect_valid = 0;
    setup_cycle();
    n_vec++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h1236) begin n_bad++; $display("FAIL rr_target got v%b %b/%h exp v0 1/1236", if_valid, imem_req, imem_addr); end
    advance();
  endtask

  task automatic test_halt();
    cfg_default(); do_reset();
    cfg_hlt_addr = 16'h0006;
    repeat (8) begin setup_cycle(); advance(); end
    setup_cycle();
    n_vec++;
    if (if_valid !== 1'b1 || if_instr !== 16'hF000 || if_pc !== 16'h0006 || halted !== 1'b1 || imem_req !== 1'b0) begin
      n_bad++; $display("FAIL halt_deliver got v%b %h %h h%b req %b exp v1 F000 0006 h1 req 0", if_valid, if_instr, if_pc, halted, imem_req);
    end
    advance();
    for (int i = 0; i < 3; i++) begin
      setup_cycle();
      n_vec++; if (imem_req !== 1'b0 || halted !== 1'b1 || if_valid !== 1'b0) begin n_bad++; $display("FAIL halt_stay i=%0d got req %b h%b v%b exp 0 1 0", i, imem_req, halted, if_valid); end
      advance();
    end
    redirect_valid = 1; redirect_pc = 16'h0010;
    setup_cycle(); advance();
    redirect_valid = 0;
    setup_cycle();
    n_vec++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0010) begin n_bad++; $display("FAIL halt_resume got h%b %b/%h exp h0 1/0010", halted, imem_req, imem_addr); end
    advance();
    cfg_hlt_addr = 16'h0001;
  endtask

  task automatic test_wrap_and_reset();
    cfg_default(); do_reset();
    cfg_ready_pct = 0; redirect_valid = 1; redirect_pc = 16'hFFFE;
    setup_cycle(); advance();
    cfg_ready_pct = 100; redirect_valid = 0;
    setup_cycle();
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 16'hFFFE) begin n_bad++; $display("FAIL wrap_req got %b/%h exp 1/FFFE", imem_req, imem_addr); end
    advance();
    setup_cycle(); advance();
    cfg_lat_min = 3; cfg_lat_max = 3;
    setup_cycle();
    n_vec++; if (if_valid !== 1'b1 || if_pc !== 16'hFFFE || if_pc_plus2 !== 16'h0000) begin n_bad++; $display("FAIL wrap_buf got v%b %h/%h exp v1 FFFE/0000", if_valid, if_pc, if_pc_plus2); end
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin n_bad++; $display("FAIL wrap_next got %b/%h exp 1/0000", imem_req, imem_addr); end
    advance();
    rst = 1;
    setup_cycle();
    n_vec++; if (imem_req !== 1'b0 || imem_addr !== 16'h0000) begin n_bad++; $display("FAIL midrst_req got %b/%h exp 0/0000", imem_req, imem_addr); end
    advance();
    rst = 0;
    setup_cycle();
    n_vec++; if (if_valid !== 1'b0 || halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0000) begin n_bad++; $display("FAIL midrst_after got v%b h%b %b/%h exp v0 h0 1/0000", if_valid, halted, imem_req, imem_addr); end
    advance();
  endtask

  task automatic test_random();
    cfg_default(); do_reset();
    cfg_ready_pct = 70; cfg_lat_min = 0; cfg_lat_max = 3; cfg_rand = 1; cfg_spur = 1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rst            = ($urandom_range(499) == 0);
      redirect_valid = ($urandom_range(19) == 0);
      redirect_pc    = 16'($urandom);
      id_ready       = ($urandom_range(3) != 0);
      setup_cycle();
      n_vec++; if (imem_req !== exp_req) begin n_bad++; $display("FAIL rnd_req cyc=%0d got %b exp %b", cyc, imem_req, exp_req); end
      if (exp_req) begin
        n_vec++; if (imem_addr !== m_pc) begin n_bad++; $display("FAIL rnd_addr cyc=%0d got %h exp %h", cyc, imem_addr, m_pc); end
      end
      n_vec++; if (if_valid !== m_bv || halted !== m_halt) begin n_bad++; $display("FAIL rnd_flags cyc=%0d got v%b h%b exp v%b h%b", cyc, if_valid, halted, m_bv, m_halt); end
      if (m_bv) begin
        n_vec++;
        if (if_instr !== m_bi || if_pc !== m_bp || if_pc_plus2 !== m_bp + 16'd2) begin
          n_bad++; $display("FAIL rnd_buf cyc=%0d got %h/%h/%h exp %h/%h/%h", cyc, if_instr, if_pc, if_pc_plus2, m_bi, m_bp, m_bp + 16'd2);
        end
      end
      advance();
    end
    rst = 0;
  endtask

  initial begin
    rst = 1; imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;
    r_pend = 0; r_cnt = 0; r_addr = 16'h0000;
    m_pc = 0; m_out = 0; m_disc = 0; m_halt = 0; m_bv = 0; m_bi = 0; m_bp = 0; exp_req = 0;
    cfg_default();
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_rvalid();
    test_halt();
    test_wrap_and_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
